// File: rtl/toggle_period_meter_if.sv
// toggle_period_meter_if: signal bundle between a toggling input source and the period meter.
interface toggle_period_meter_if #(parameter int WIDTH = 16);
    logic             sig_in;
    logic             sig_level;
    logic [WIDTH-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             stalled;
    modport master (output sig_in, input sig_level, half_period, meas_valid, locked, stalled);
    modport slave  (input sig_in, output sig_level, half_period, meas_valid, locked, stalled);
endinterface

// File: rtl/toggle_period_meter.sv
// toggle_period_meter: measures clk cycles between edges of a slow toggling input and flags lock/stall.
module toggle_period_meter #(
    parameter int WIDTH    = 16,
    parameter int EXPECTED = 750,
    parameter int TOL      = 2,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 4000
) (
    input logic                  clk,
    input logic                  rst,
    toggle_period_meter_if.slave bus
);
    localparam logic [WIDTH:0]   LO   = (WIDTH+1)'(EXPECTED >= TOL ? EXPECTED - TOL : 0);
    localparam logic [WIDTH:0]   HI   = (WIDTH+1)'(EXPECTED + TOL);
    localparam logic [WIDTH-1:0] CMAX = '1;
    localparam logic [WIDTH-1:0] TMO  = WIDTH'(TIMEOUT);
    localparam int               MW   = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]    LN   = MW'(LOCK_N);

    typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;

    state_t           state, state_n;
    logic             s1, s2, dly, edg, report, stall_go, match;
    logic [WIDTH-1:0] cnt;
    logic [MW-1:0]    mcnt, mcnt_inc;

    assign edg           = s2 ^ dly;
    assign bus.sig_level = s2;
    // Extra top bit keeps the tolerance window from wrapping near the counter limit.
    assign match         = ({1'b0, cnt} >= LO) && ({1'b0, cnt} <= HI);
    assign mcnt_inc      = (mcnt == LN) ? mcnt : mcnt + 1'b1;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n  = state;
        report   = 1'b0;
        stall_go = 1'b0;
        case (state)
            IDLE:    state_n = edg ? MEASURE : IDLE;
            MEASURE: begin
                report   = edg;
                stall_go = !edg && (cnt == TMO);
                state_n  = stall_go ? STALL : MEASURE;
            end
            STALL:   state_n = edg ? MEASURE : STALL;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1              <= 1'b0;
            s2              <= 1'b0;
            dly             <= 1'b0;
            cnt             <= '0;
            mcnt            <= '0;
            bus.half_period <= '0;
            bus.meas_valid  <= 1'b0;
            bus.locked      <= 1'b0;
            bus.stalled     <= 1'b0;
        end else begin
            s1             <= bus.sig_in;
            s2             <= s1;
            dly            <= s2;
            cnt            <= edg ? WIDTH'(1) : (cnt == CMAX ? cnt : cnt + 1'b1);
            bus.meas_valid <= report;
            bus.stalled    <= (state_n == STALL);
            if (report) begin
                bus.half_period <= cnt;
                mcnt            <= match ? mcnt_inc : '0;
                bus.locked      <= match && (mcnt_inc == LN);
            end else if (stall_go) begin
                mcnt       <= '0;
                bus.locked <= 1'b0;
            end
        end
    end
endmodule
